// File: rtl/single_port_ram_ctrl_if.sv
// ----------------------------------------------------------------------------
// single_port_ram_ctrl_if
//   Request/response bus of the single-port RAM sequencer.
//   Request channel  : req_valid / req_ready handshake carrying req_we,
//                      req_addr and req_wdata (wdata ignored for reads).
//   Response channel : rsp_valid / rsp_ready handshake carrying rsp_rdata.
//   master modport   : the requester (drives requests, consumes responses).
//   slave modport    : the sequencer (accepts requests, returns responses).
// ----------------------------------------------------------------------------
interface single_port_ram_ctrl_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/single_port_ram_ctrl.sv
// ----------------------------------------------------------------------------
// single_port_ram_ctrl
//   Sequencer placed directly upstream of single_port_ram. It accepts read and
//   write requests, serialises them onto the RAM's single port through
//   registered data/addr/we outputs, captures the RAM's q for reads and holds
//   the read data on the response channel until the consumer takes it. A bulk
//   clear writes zero to every RAM word.
//
// Ports
//   clk        : single clock, shared with single_port_ram
//   rst        : synchronous, active-high reset
//   bus        : request/response interface (slave side)
//   clr_start  : start bulk clear; only looked at in IDLE, never queued
//   busy       : high in every state except IDLE
//   ram_data   : to single_port_ram.data (registered)
//   ram_addr   : to single_port_ram.addr (registered)
//   ram_we     : to single_port_ram.we   (registered)
//   ram_q      : from single_port_ram.q, valid the cycle after addr is sampled
// ----------------------------------------------------------------------------
module single_port_ram_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  single_port_ram_ctrl_if.slave   bus,
  input  logic                    clr_start,
  output logic                    busy,
  output logic [DATA_WIDTH-1:0]   ram_data,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic                    ram_we,
  input  logic [DATA_WIDTH-1:0]   ram_q
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    RSP,
    CLEAR
  } state_t;

  // One bit wider than the address so DEPTH == 2**ADDR_WIDTH can be reached
  // and compared without the counter wrapping back to zero.
  localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

  state_t                  state_reg,     state_next;
  logic                    ram_we_reg,    ram_we_next;
  logic [ADDR_WIDTH-1:0]   ram_addr_reg,  ram_addr_next;
  logic [DATA_WIDTH-1:0]   ram_data_reg,  ram_data_next;
  logic                    rsp_valid_reg, rsp_valid_next;
  logic [DATA_WIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;
  logic [ADDR_WIDTH:0]     clr_cnt_reg,   clr_cnt_next;
  logic [ADDR_WIDTH:0]     clr_cnt_inc;
  logic                    accept;

  // A same-cycle clear request wins over a pending request, so ready is
  // withheld while clr_start is high and the requester keeps its request.
  assign bus.req_ready = (state_reg == IDLE) && !clr_start;
  assign accept        = bus.req_valid && bus.req_ready;
  assign clr_cnt_inc   = clr_cnt_reg + 1'b1;

  assign busy          = (state_reg != IDLE);
  assign ram_we        = ram_we_reg;
  assign ram_addr      = ram_addr_reg;
  assign ram_data      = ram_data_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ram_we_reg    <= 1'b0;
      ram_addr_reg  <= '0;
      ram_data_reg  <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      clr_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      ram_we_reg    <= ram_we_next;
      ram_addr_reg  <= ram_addr_next;
      ram_data_reg  <= ram_data_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      clr_cnt_reg   <= clr_cnt_next;
    end
  end

  always_comb begin
    // Write enable is a one-cycle pulse; address and data hold by default.
    state_next     = state_reg;
    ram_we_next    = 1'b0;
    ram_addr_next  = ram_addr_reg;
    ram_data_next  = ram_data_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
    clr_cnt_next   = clr_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (clr_start) begin
          // First clear word is presented in the first CLEAR cycle.
          state_next    = CLEAR;
          ram_we_next   = 1'b1;
          ram_addr_next = '0;
          ram_data_next = '0;
          clr_cnt_next  = '0;
        end else if (accept) begin
          // Addresses are forwarded unchanged, with no range check.
          ram_addr_next = bus.req_addr;
          if (bus.req_we) begin
            // Writes stay in IDLE so back-to-back writes run at full rate.
            ram_we_next   = 1'b1;
            ram_data_next = bus.req_wdata;
          end else begin
            state_next = RD_ADDR;
          end
        end
      end

      RD_ADDR: begin
        // RAM samples the read address at the end of this cycle.
        state_next = RD_DATA;
      end

      RD_DATA: begin
        rsp_rdata_next = ram_q;
        rsp_valid_next = 1'b1;
        state_next     = RSP;
      end

      RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end

      CLEAR: begin
        if (clr_cnt_reg == CLR_LAST) begin
          clr_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          clr_cnt_next  = clr_cnt_inc;
          ram_we_next   = 1'b1;
          ram_addr_next = clr_cnt_inc[ADDR_WIDTH-1:0];
          ram_data_next = '0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_single_port_ram_ctrl.sv
// ----------------------------------------------------------------------------
// tb_single_port_ram_ctrl
//   Directed scenarios followed by randomized traffic. A behavioural model of
//   the RAM contents and of the expected RAM-port/response activity (queued
//   per cycle) is checked against the DUT on every falling edge. Directed
//   scenarios also register literal expectations ("pins") for specific cycles.
// ----------------------------------------------------------------------------
module tb_single_port_ram_ctrl;

  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr_start = 1'b0;
  logic          busy;
  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  single_port_ram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  single_port_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clr_start (clr_start),
    .busy      (busy),
    .ram_data  (ram_data),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_q     (ram_q)
  );

  always #5 clk = ~clk;

  // Environment: single-port RAM with registered read.
  logic [DW-1:0] env_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) env_mem[ram_addr] <= ram_data;
    ram_q <= env_mem[ram_addr];
  end

  // ---------------- shared state (each variable has a single writer) -------
  int errors = 0;
  int checks = 0;
  int tmo_cnt = 0;        // written by stimulus only
  int tmo_seen = 0;       // written by compare only
  int pin_kind [128];
  int pin_val  [128];
  int pin_n = 0;          // written by stimulus only
  int pin_done = 0;       // written by compare only
  bit rnd_mode = 0;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic          we;
    logic          ca;
    logic          cd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ram_exp_t;

  ram_exp_t      exp_q [$];
  logic [DW-1:0] ref_mem   [DEPTH];
  bit            ref_known [DEPTH];
  bit            armed = 0;
  bit            rd_out = 0;
  int            rd_wait = 0;
  logic [DW-1:0] rd_val;
  bit            rd_known = 0;
  int            clr_left = 0;
  ram_exp_t      cur;
  bit            eb, er, ev;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    eb = rd_out || (clr_left > 0);
    er = !eb && !clr_start;
    ev = rd_out && (rd_wait == 0);

    if (armed) begin
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = '{we: 1'b0, ca: 1'b0, cd: 1'b0, addr: '0, data: '0};
      chk("ram_we", 32'(ram_we), 32'(cur.we));
      if (cur.ca) chk("ram_addr", 32'(ram_addr), 32'(cur.addr));
      if (cur.cd) chk("ram_data", 32'(ram_data), 32'(cur.data));
      chk("busy", 32'(busy), 32'(eb));
      chk("req_ready", 32'(bus.req_ready), 32'(er));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
      if (ev && rd_known) chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(rd_val));
    end

    while (pin_done < pin_n) begin
      case (pin_kind[pin_done])
        0: chk("pin_ram_we",    32'(ram_we),        32'(pin_val[pin_done]));
        1: chk("pin_ram_addr",  32'(ram_addr),      32'(pin_val[pin_done]));
        2: chk("pin_ram_data",  32'(ram_data),      32'(pin_val[pin_done]));
        3: chk("pin_busy",      32'(busy),          32'(pin_val[pin_done]));
        4: chk("pin_req_ready", 32'(bus.req_ready), 32'(pin_val[pin_done]));
        5: chk("pin_rsp_valid", 32'(bus.rsp_valid), 32'(pin_val[pin_done]));
        default: chk("pin_rsp_rdata", 32'(bus.rsp_rdata), 32'(pin_val[pin_done]));
      endcase
      pin_done++;
    end

    if (tmo_cnt != tmo_seen) begin
      chk("handshake_timeout", 32'(tmo_cnt), 32'(tmo_seen));
      tmo_seen = tmo_cnt;
    end

    // Advance the model by the coming rising edge, using the inputs that
    // will be sampled there.
    if (rst) begin
      exp_q.delete();
      exp_q.push_back('{we: 1'b0, ca: 1'b1, cd: 1'b1, addr: '0, data: '0});
      if (clr_left > 0) for (int k = 0; k < DEPTH; k++) ref_known[k] = 0;
      rd_out   = 0;
      clr_left = 0;
      armed    = 1;
    end else if (armed) begin
      if (ev && bus.rsp_ready) rd_out = 0;
      else if (rd_out && rd_wait > 0) rd_wait--;
      if (clr_left > 0) clr_left--;
      if (!eb && clr_start) begin
        clr_left = DEPTH;
        for (int k = 0; k < DEPTH; k++) begin
          exp_q.push_back('{we: 1'b1, ca: 1'b1, cd: 1'b1, addr: AW'(k), data: '0});
          ref_mem[k]   = '0;
          ref_known[k] = 1;
        end
      end else if (er && bus.req_valid) begin
        if (bus.req_we) begin
          exp_q.push_back('{we: 1'b1, ca: 1'b1, cd: 1'b1, addr: bus.req_addr, data: bus.req_wdata});
          ref_mem[bus.req_addr]   = bus.req_wdata;
          ref_known[bus.req_addr] = 1;
        end else begin
          exp_q.push_back('{we: 1'b0, ca: 1'b1, cd: 1'b0, addr: bus.req_addr, data: '0});
          rd_out   = 1;
          rd_wait  = 2;
          rd_val   = ref_mem[bus.req_addr];
          rd_known = ref_known[bus.req_addr];
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
    if (rnd_mode) bus.rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic pin(input int k, input int v);
    pin_kind[pin_n] = k;
    pin_val[pin_n]  = v;
    pin_n++;
  endtask

  // Presents a request and holds it until accepted; returns one cycle after
  // the accepting edge with req_valid still high.
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit done;
    int n;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    done = 0;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      done = bus.req_ready;
      cyc();
      n++;
    end
    if (!done) begin
      tmo_cnt++;
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic rd_check(input logic [AW-1:0] a, input int want);
    send(1'b0, a, '0);
    bus.req_valid = 1'b0;
    pin(5, 0);
    cyc();
    pin(5, 0);
    cyc();
    pin(5, 1);
    pin(6, want);
    bus.rsp_ready = 1'b1;
    cyc();
    bus.rsp_ready = 1'b0;
    pin(4, 1);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    // 1: reset held two cycles
    cyc();
    cyc();
    rst = 1'b0;
    pin(0, 0); pin(5, 0); pin(3, 0); pin(4, 1); pin(1, 0); pin(6, 0);
    cyc();

    // 2: back-to-back writes, then reads
    send(1'b1, 6'd0, 8'h01);
    pin(0, 1); pin(1, 0); pin(2, 8'h01);
    send(1'b1, 6'd1, 8'h02);
    pin(0, 1); pin(1, 1); pin(2, 8'h02);
    send(1'b1, 6'd2, 8'h03);
    bus.req_valid = 1'b0;
    pin(0, 1); pin(1, 2); pin(2, 8'h03);
    cyc();
    pin(0, 0);
    rd_check(6'd0, 8'h01);
    rd_check(6'd1, 8'h02);
    rd_check(6'd2, 8'h03);

    // 3: response held under back-pressure
    send(1'b0, 6'd1, '0);
    bus.req_valid = 1'b0;
    cyc();
    cyc();
    for (int i = 0; i < 5; i++) begin
      pin(5, 1); pin(6, 8'h02); pin(4, 0);
      cyc();
    end
    bus.rsp_ready = 1'b1;
    cyc();
    bus.rsp_ready = 1'b0;
    pin(4, 1); pin(5, 0);
    cyc();

    // 4: read-after-write at the top address
    send(1'b1, 6'd63, 8'hA5);
    send(1'b0, 6'd63, '0);
    bus.req_valid = 1'b0;
    cyc();
    cyc();
    pin(5, 1); pin(6, 8'hA5);
    bus.rsp_ready = 1'b1;
    cyc();
    bus.rsp_ready = 1'b0;

    // 5: clear wins over a same-cycle read; the held read follows
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 6'd2;
    clr_start     = 1'b1;
    pin(4, 0);
    cyc();
    clr_start = 1'b0;
    pin(3, 1); pin(0, 1); pin(1, 0); pin(2, 0); pin(4, 0);
    repeat (63) cyc();
    pin(3, 1); pin(0, 1); pin(1, 63);
    cyc();
    pin(3, 0); pin(0, 0); pin(4, 1);
    rd_check(6'd2, 8'h00);
    cyc();

    // 6: reset during a clear
    clr_start = 1'b1;
    cyc();
    clr_start = 1'b0;
    repeat (10) cyc();
    pin(1, 10); pin(0, 1); pin(3, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    pin(0, 0); pin(3, 0); pin(5, 0); pin(4, 1);
    cyc();

    // Randomized traffic after a fresh clear
    rnd_mode  = 1;
    clr_start = 1'b1;
    cyc();
    clr_start = 1'b0;
    repeat (66) cyc();
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        clr_start = 1'b1;
        cyc();
        clr_start = 1'b0;
      end else begin
        send(1'(r < 50), AW'($urandom_range(0, DEPTH - 1)), DW'($urandom_range(0, 255)));
        bus.req_valid = 1'b0;
      end
      repeat ($urandom_range(0, 2)) cyc();
    end
    rnd_mode      = 0;
    bus.rsp_ready = 1'b1;
    repeat (80) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
